multi_sel_chk: RTL and testbench
================================

// Module: multi_sel_chk
// PURPOSE
//  Receive-side decoder/checker for the 4-word multiplier frame stream produced by the
//  multi_sel transmit block. Frame: word0 = d, word1 = 3*d, word2 = 7*d, word3 = 9*d.
//  All words are truncated mod 2^OW; in_grant marks word0.
//  Recovers d, checks the three derived words, reports one result per frame and keeps
//  frame/error statistics. Sits directly on the multi_sel output bus; one clock domain.
// PARAMETERS
//  DW  8   width of payload d
//  OW  11  width of stream word; must be >= DW
//  CW  16  width of frame_cnt and err_cnt statistics counters
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   reset, synchronous, active-low
//  in_data    in   OW  stream word, sampled every clock
//  in_grant   in   1   high marks in_data as word0 (start of frame)
//  d_out      out  DW  recovered payload of last completed frame
//  d_valid    out  1   one-cycle pulse: frame complete, d_out/d_err valid
//  d_err      out  1   frame failed check; qualified by d_valid
//  sync_err   out  1   one-cycle pulse: frame aborted by early in_grant
//  frame_cnt  out  CW  completed frames (good + bad), saturating
//  err_cnt    out  CW  bad frames + aborted frames, saturating
// BEHAVIOUR
//  Reset:
//  - rst=0 at a rising edge: all outputs 0, state IDLE, base/mismatch regs 0.
//  - Applies mid-frame too: the partial frame is discarded with no pulse.
//  FSM (one transition per clock):
//  - IDLE: in_grant=1 -> capture base=in_data[DW-1:0], hi_bad=|in_data[OW-1:DW],
//    clear mism, go W1. Otherwise stay; in_data is ignored.
//  - W1/W2/W3: compare in_data to the expected value and OR any mismatch into mism.
//    W1 expects 3*base, W2 expects 7*base, W3 expects 9*base.
//    Expected values are computed at OW bits and truncated mod 2^OW,
//    e.g. 9*255 = 2295 -> 247.
//  - W3 edge: d_out<=base, d_valid<=1, d_err<=mism|hi_bad|W3 mismatch,
//    frame_cnt+1, err_cnt+1 if d_err. Next state IDLE, or W1 if in_grant=1 on this
//    same edge (in_grant sampled in W3 is treated as word0 of the next frame, which
//    supports back-to-back frames).
//  - in_grant=1 in W1 or W2: the current frame is aborted.
//    - sync_err pulses 1 cycle, err_cnt+1, no d_valid for the aborted frame.
//    - The word is taken as word0 of a new frame; go W1.
//  Latency: d_valid is high in the cycle after word3 is sampled (1 clock after word3).
//  d_out and d_err hold until the next d_valid; d_valid and sync_err are 1-cycle pulses.
//  Counters saturate at 2^CW-1 (no wrap). Simultaneous frame-error and saturation:
//  the counter holds its value.
//  d_err and sync_err never assert in the same cycle.
// TESTING
//  1 grant+5,15,35,45 -> cycle after word3: d_valid=1, d_out=5, d_err=0, frame_cnt=1
//  2 grant+255,765,1785,247 -> d_out=255, d_err=0 (truncation of 9*d accepted)
//  3 grant+5,15,36,45 -> d_valid=1, d_out=5, d_err=1, err_cnt=1
//  4 grant+5,15 then grant+9,27,63,81 -> sync_err pulse, then d_out=9, d_err=0,
//    frame_cnt=1, err_cnt=1
//  5 rst=0 during W2 -> next edge all outputs 0; words without grant ignored; no d_valid
//  6 base word 0x105 (upper bits set) + 15,35,45 -> d_valid=1, d_out=5, d_err=1

Source files
------------

// File: rtl/multi_sel_chk_if.sv
// Stream input and per-frame result bus for the multi_sel frame checker.
// The master side drives the stream and observes results. The slave side is the checker.
interface multi_sel_chk_if #(
  parameter int DW = 8,
  parameter int OW = 11,
  parameter int CW = 16
);
  logic [OW-1:0] in_data;
  logic          in_grant;
  logic [DW-1:0] d_out;
  logic          d_valid;
  logic          d_err;
  logic          sync_err;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_cnt;

  modport master (
    output in_data, in_grant,
    input  d_out, d_valid, d_err, sync_err, frame_cnt, err_cnt
  );

  modport slave (
    input  in_data, in_grant,
    output d_out, d_valid, d_err, sync_err, frame_cnt, err_cnt
  );
endinterface

// File: rtl/multi_sel_chk.sv
// Checks 4-word frames {d, 3d, 7d, 9d} (mod 2^OW) and keeps saturating frame/error counts.
// Result is registered 1 clock after word3. There is no backpressure: a word is consumed every clock.
module multi_sel_chk #(
  parameter int DW = 8,
  parameter int OW = 11,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  multi_sel_chk_if.slave bus
);

  typedef enum logic [1:0] {IDLE, W1, W2, W3} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_nxt;
  logic [DW-1:0] base, base_nxt;
  logic          hi_bad, hi_bad_nxt;
  logic          mism, mism_nxt;
  logic [DW-1:0] d_out, d_out_nxt;
  logic          d_valid, d_valid_nxt;
  logic          d_err, d_err_nxt;
  logic          sync_err, sync_err_nxt;
  logic [CW-1:0] frame_cnt, frame_cnt_nxt;
  logic [CW-1:0] err_cnt, err_cnt_nxt;

  logic [OW-1:0] base_ext, exp3, exp7, exp9, hi_bits;
  logic          fc_inc, ec_inc, w3_err;

  // Expected words are formed at stream width, so products wrap mod 2^OW.
  always_comb begin
    base_ext = OW'(base);
    exp3     = base_ext * OW'(3);
    exp7     = base_ext * OW'(7);
    exp9     = base_ext * OW'(9);
    hi_bits  = bus.in_data >> DW;
  end

  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    hi_bad_nxt   = hi_bad;
    mism_nxt     = mism;
    d_out_nxt    = d_out;
    d_valid_nxt  = 1'b0;
    d_err_nxt    = d_err;
    sync_err_nxt = 1'b0;
    fc_inc       = 1'b0;
    ec_inc       = 1'b0;
    w3_err       = 1'b0;

    case (state)
      IDLE: ;
      W1: begin
        if (bus.in_grant) begin
          sync_err_nxt = 1'b1;
          ec_inc       = 1'b1;
        end else begin
          mism_nxt  = mism | (bus.in_data != exp3);
          state_nxt = W2;
        end
      end
      W2: begin
        if (bus.in_grant) begin
          sync_err_nxt = 1'b1;
          ec_inc       = 1'b1;
        end else begin
          mism_nxt  = mism | (bus.in_data != exp7);
          state_nxt = W3;
        end
      end
      W3: begin
        w3_err      = mism | hi_bad | (bus.in_data != exp9);
        d_out_nxt   = base;
        d_valid_nxt = 1'b1;
        d_err_nxt   = w3_err;
        fc_inc      = 1'b1;
        ec_inc      = w3_err;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A grant in any state starts a new frame (after finishing or aborting the current one).
    if (bus.in_grant) begin
      base_nxt   = bus.in_data[DW-1:0];
      hi_bad_nxt = |hi_bits;
      mism_nxt   = 1'b0;
      state_nxt  = W1;
    end

    frame_cnt_nxt = (fc_inc && frame_cnt != CNT_MAX) ? frame_cnt + 1'b1 : frame_cnt;
    err_cnt_nxt   = (ec_inc && err_cnt != CNT_MAX) ? err_cnt + 1'b1 : err_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      hi_bad    <= 1'b0;
      mism      <= 1'b0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      d_err     <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      base      <= base_nxt;
      hi_bad    <= hi_bad_nxt;
      mism      <= mism_nxt;
      d_out     <= d_out_nxt;
      d_valid   <= d_valid_nxt;
      d_err     <= d_err_nxt;
      sync_err  <= sync_err_nxt;
      frame_cnt <= frame_cnt_nxt;
      err_cnt   <= err_cnt_nxt;
    end
  end

  assign bus.d_out     = d_out;
  assign bus.d_valid   = d_valid;
  assign bus.d_err     = d_err;
  assign bus.sync_err  = sync_err;
  assign bus.frame_cnt = frame_cnt;
  assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_multi_sel_chk.sv
// Directed vector bench for multi_sel_chk, with a narrow-counter instance for saturation.
module tb_multi_sel_chk;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_sel_chk_if #(.DW(8), .OW(11), .CW(16)) bus ();
  multi_sel_chk_if #(.DW(8), .OW(11), .CW(3))  sbus ();

  multi_sel_chk #(.DW(8), .OW(11), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  multi_sel_chk #(.DW(8), .OW(11), .CW(3))  dut_sat (.clk(clk), .rst(rst), .bus(sbus.slave));

  typedef struct {
    logic        rst;
    logic        grant;
    logic [10:0] data;
    logic        vld;
    logic [7:0]  dout;
    logic        err;
    logic        sync;
    logic [15:0] fc;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic add(input logic r, input logic g, input logic [10:0] d,
                     input logic v, input logic [7:0] o, input logic e,
                     input logic s, input logic [15:0] f, input logic [15:0] c);
    vec_t t;
    t.rst = r; t.grant = g; t.data = d; t.vld = v; t.dout = o;
    t.err = e; t.sync = s; t.fc = f; t.ec = c;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic sframe(input logic [7:0] b, input logic bad);
    logic [10:0] w;
    w = {3'b000, b};
    sbus.in_grant = 1'b1; sbus.in_data = w;          @(posedge clk); #1;
    sbus.in_grant = 1'b0; sbus.in_data = w * 11'd3;  @(posedge clk); #1;
    sbus.in_data = w * 11'd7;                        @(posedge clk); #1;
    sbus.in_data = w * 11'd9 + {10'd0, bad};         @(posedge clk); #1;
    sbus.in_data = '0;
  endtask

  initial begin
    bus.in_grant  = 1'b0; bus.in_data  = '0;
    sbus.in_grant = 1'b0; sbus.in_data = '0;

    // rst grant data | vld dout err sync fc ec
    add(0,0,0,    0,0,0,0,0,0);
    // good frame d=5
    add(1,1,5,    0,0,0,0,0,0);
    add(1,0,15,   0,0,0,0,0,0);
    add(1,0,35,   0,0,0,0,0,0);
    add(1,0,45,   1,5,0,0,1,0);
    add(1,0,0,    0,5,0,0,1,0);
    // d=255, 9*d truncates to 247
    add(1,1,255,  0,5,0,0,1,0);
    add(1,0,765,  0,5,0,0,1,0);
    add(1,0,1785, 0,5,0,0,1,0);
    add(1,0,247,  1,255,0,0,2,0);
    add(1,0,0,    0,255,0,0,2,0);
    // bad word2
    add(1,1,5,    0,255,0,0,2,0);
    add(1,0,15,   0,255,0,0,2,0);
    add(1,0,36,   0,255,0,0,2,0);
    add(1,0,45,   1,5,1,0,3,1);
    add(1,0,0,    0,5,1,0,3,1);
    // abort in W2, then good frame d=9
    add(1,1,5,    0,5,1,0,3,1);
    add(1,0,15,   0,5,1,0,3,1);
    add(1,1,9,    0,5,1,1,3,2);
    add(1,0,27,   0,5,1,0,3,2);
    add(1,0,63,   0,5,1,0,3,2);
    add(1,0,81,   1,9,0,0,4,2);
    add(1,0,0,    0,9,0,0,4,2);
    // upper bits set on base word
    add(1,1,261,  0,9,0,0,4,2);
    add(1,0,15,   0,9,0,0,4,2);
    add(1,0,35,   0,9,0,0,4,2);
    add(1,0,45,   1,5,1,0,5,3);
    add(1,0,0,    0,5,1,0,5,3);
    // grant on word3 doubles as word0 of next frame (d=27)
    add(1,1,3,    0,5,1,0,5,3);
    add(1,0,9,    0,5,1,0,5,3);
    add(1,0,21,   0,5,1,0,5,3);
    add(1,1,27,   1,3,0,0,6,3);
    add(1,0,81,   0,3,0,0,6,3);
    add(1,0,189,  0,3,0,0,6,3);
    add(1,0,243,  1,27,0,0,7,3);
    add(1,0,0,    0,27,0,0,7,3);
    // abort in W1, then good frame d=2
    add(1,1,4,    0,27,0,0,7,3);
    add(1,1,2,    0,27,0,1,7,4);
    add(1,0,6,    0,27,0,0,7,4);
    add(1,0,14,   0,27,0,0,7,4);
    add(1,0,18,   1,2,0,0,8,4);
    add(1,0,0,    0,2,0,0,8,4);
    // reset during W2, then words without grant are ignored
    add(1,1,5,    0,2,0,0,8,4);
    add(1,0,15,   0,2,0,0,8,4);
    add(0,0,35,   0,0,0,0,0,0);
    add(1,0,45,   0,0,0,0,0,0);
    add(1,0,15,   0,0,0,0,0,0);
    add(1,0,35,   0,0,0,0,0,0);
    add(1,0,45,   0,0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst          = vecs[i].rst;
      bus.in_grant = vecs[i].grant;
      bus.in_data  = vecs[i].data;
      @(posedge clk); #1;
      check("d_valid",   i, {31'd0, bus.d_valid},  {31'd0, vecs[i].vld});
      check("d_out",     i, {24'd0, bus.d_out},    {24'd0, vecs[i].dout});
      check("d_err",     i, {31'd0, bus.d_err},    {31'd0, vecs[i].err});
      check("sync_err",  i, {31'd0, bus.sync_err}, {31'd0, vecs[i].sync});
      check("frame_cnt", i, {16'd0, bus.frame_cnt}, {16'd0, vecs[i].fc});
      check("err_cnt",   i, {16'd0, bus.err_cnt},  {16'd0, vecs[i].ec});
    end
    bus.in_grant = 1'b0;
    bus.in_data  = '0;

    // Saturation on the 3-bit counter instance: bad frames bump both counters.
    rst = 1'b0; @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 7; k++) sframe(8'd1, 1'b1);
    check("sat_fc_at_max", 0, {29'd0, sbus.frame_cnt}, 32'd7);
    check("sat_ec_at_max", 0, {29'd0, sbus.err_cnt},   32'd7);
    for (int k = 0; k < 2; k++) sframe(8'd1, 1'b1);
    check("sat_fc_hold", 0, {29'd0, sbus.frame_cnt}, 32'd7);
    check("sat_ec_hold", 0, {29'd0, sbus.err_cnt},   32'd7);
    check("sat_d_err",   0, {31'd0, sbus.d_err},     32'd1);
    sframe(8'd4, 1'b0);
    check("sat_good_fc",  0, {29'd0, sbus.frame_cnt}, 32'd7);
    check("sat_good_err", 0, {31'd0, sbus.d_err},     32'd0);
    check("sat_good_out", 0, {24'd0, sbus.d_out},     32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
